// File: rtl/hw_always_sched_pkg.sv
// hw_always_sched_pkg: shared widths, FSM state encodings and select codes for the scheduler
package hw_always_sched_pkg;
    localparam int DW_DEF = 3;
    localparam int SW_DEF = 2;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;
    localparam logic [1:0] SEL0 = 2'h0;
    localparam logic [1:0] SEL1 = 2'h1;
    localparam logic [1:0] SEL2 = 2'h2;
    localparam logic [1:0] SEL3 = 2'h3;
endpackage

// File: rtl/hw_always_sched_rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter producing a one-hot grant
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);
    // under contention the requester that did not win last time is granted
    always_comb begin
        gnt = 2'b00;
        gnt = !en ? 2'b00 : (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
    end
endmodule

// File: rtl/hw_always_sched.sv
// hw_always_sched: round-robin sharing of one combinational hw_always datapath between two requesters
module hw_always_sched
    import hw_always_sched_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_din0,
    input  logic [DW-1:0] req0_din1,
    input  logic [SW-1:0] req0_sel,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_din0,
    input  logic [DW-1:0] req1_din1,
    input  logic [SW-1:0] req1_sel,
    output logic [DW-1:0] dp_din0,
    output logic [DW-1:0] dp_din1,
    output logic [SW-1:0] dp_sel,
    input  logic [DW-1:0] dp_dout,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data
);
    state_t     state, state_nx;
    logic       last_grant;
    logic [1:0] gnt;
    logic       accept;

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .en         (state == ST_IDLE && !rst),
        .gnt        (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign accept     = |gnt;

    // next state: one cycle driving the datapath, then hold the response until it is taken
    always_comb begin
        state_nx = state;
        state_nx = (state == ST_IDLE)  ? (accept ? ST_DRIVE : ST_IDLE) :
                   (state == ST_DRIVE) ? ST_RESP :
                   (rsp_ready ? ST_IDLE : ST_RESP);
    end

    // operand capture on accept, result capture after the drive cycle, response retire on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            dp_din0    <= '0;
            dp_din1    <= '0;
            dp_sel     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dp_din0    <= gnt[1] ? req1_din0 : req0_din0;
                dp_din1    <= gnt[1] ? req1_din1 : req0_din1;
                dp_sel     <= gnt[1] ? req1_sel : req0_sel;
                rsp_id     <= gnt[1];
                last_grant <= gnt[1];
            end
            if (state == ST_DRIVE) begin
                rsp_data  <= dp_dout;
                rsp_valid <= 1'b1;
            end
            if (state == ST_RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule
